// File: rtl/svi_serial_tx_if.sv
// Three-signal serial bundle: x = bit strobe, y = serial data, z = last bit of frame.
// P2 is the producing side, P1 the consuming side.
interface svi_serial_tx_if;
  logic x;
  logic y;
  logic z;

  modport P2 (output x, y, z);
  modport P1 (input  x, y, z);
endinterface

// File: rtl/svi_serial_tx.sv
// Parallel-to-serial frame transmitter, MSB first, driving the bundle through p2.
// Optional forced idle gap between frames; back-to-back reload when GAP is zero.
module svi_serial_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GAP   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  svi_serial_tx_if.P2      p2,
  output logic             busy,
  output logic [15:0]      frame_cnt
);
  localparam int unsigned RW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [RW-1:0]    r_rem;
  logic [7:0]       r_gap;
  logic             r_x;
  logic             r_z;
  logic [15:0]      r_cnt;
  logic             w_last;
  logic             w_accept;

  assign w_last   = (r_state == S_SHIFT) && (r_rem == '0);
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (r_rem == '0) begin
          if (GAP > 0)       w_state_nxt = S_GAP;
          else if (w_accept) w_state_nxt = S_SHIFT;
          else               w_state_nxt = S_IDLE;
        end
      end
      S_GAP:   if (r_gap == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = (r_state != S_IDLE);
    if (rst_n) in_ready = (r_state == S_IDLE) || (w_last && (GAP == 0));
  end

  // y is the shift register MSB; clearing the register at frame end returns y to 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_rem   <= '0;
      r_gap   <= '0;
      r_x     <= 1'b0;
      r_z     <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_last) r_cnt <= r_cnt + 16'd1;
      if (w_accept) begin
        r_shift <= in_data;
        r_x     <= 1'b1;
        r_rem   <= RW'(WIDTH - 1);
        r_z     <= (WIDTH == 1);
      end else if (r_state == S_SHIFT) begin
        if (r_rem != '0) begin
          r_shift <= r_shift << 1;
          r_rem   <= r_rem - RW'(1);
          r_z     <= (r_rem == RW'(1));
        end else begin
          r_shift <= '0;
          r_x     <= 1'b0;
          r_z     <= 1'b0;
          r_gap   <= (GAP > 0) ? 8'(GAP - 1) : '0;
        end
      end else if ((r_state == S_GAP) && (r_gap != '0)) begin
        r_gap <= r_gap - 8'd1;
      end
    end
  end

  assign p2.x      = r_x;
  assign p2.y      = r_shift[WIDTH-1];
  assign p2.z      = r_z;
  assign frame_cnt = r_cnt;
endmodule

// File: tb/tb_svi_serial_tx.sv
// Bench for svi_serial_tx: three instances (8/2, 4/0, 1/0) checked every cycle
// against a frame-timing model, plus directed literal checks.
module tb_svi_serial_tx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vin [3];
  logic [63:0] dat [3];
  logic        rdy [3];
  logic        bsy [3];
  logic [15:0] cnt [3];
  logic        ox  [3];
  logic        oy  [3];
  logic        oz  [3];

  int checks   = 0;
  int failures = 0;

  int wv [3] = '{8, 4, 1};
  int gv [3] = '{2, 0, 0};

  svi_serial_tx_if bus0 ();
  svi_serial_tx_if bus1 ();
  svi_serial_tx_if bus2 ();

  svi_serial_tx #(.WIDTH(8), .GAP(2)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(vin[0]), .in_ready(rdy[0]),
    .in_data(dat[0][7:0]), .p2(bus0), .busy(bsy[0]), .frame_cnt(cnt[0]));
  svi_serial_tx #(.WIDTH(4), .GAP(0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(vin[1]), .in_ready(rdy[1]),
    .in_data(dat[1][3:0]), .p2(bus1), .busy(bsy[1]), .frame_cnt(cnt[1]));
  svi_serial_tx #(.WIDTH(1), .GAP(0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(vin[2]), .in_ready(rdy[2]),
    .in_data(dat[2][0:0]), .p2(bus2), .busy(bsy[2]), .frame_cnt(cnt[2]));

  assign ox[0] = bus0.x; assign oy[0] = bus0.y; assign oz[0] = bus0.z;
  assign ox[1] = bus1.x; assign oy[1] = bus1.y; assign oz[1] = bus1.z;
  assign ox[2] = bus2.x; assign oy[2] = bus2.y; assign oz[2] = bus2.z;

  always #5 clk = ~clk;

  // Model: a frame accepted at edge e occupies cycles e..e+W-1, completes at edge e+W,
  // and the block is next ready in cycle e+W-1 (GAP=0) or e+W+GAP (GAP>0).
  int          m = 0;
  bit          started = 1'b0;
  bit          act  [3];
  int          e    [3];
  int          fr   [3];
  int          bend [3];
  logic [63:0] md   [3];
  logic [15:0] mcnt [3];

  always @(negedge clk) begin
    logic ex, ey, ez, er, eb;
    logic [20:0] got, exp;
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        ex = act[i];
        ey = 1'b0;
        if (act[i]) ey = md[i][wv[i] - 1 - (m - e[i])];
        ez = act[i] && (m == e[i] + wv[i] - 1);
        er = rst_n && (m >= fr[i]);
        eb = (m < bend[i]);
        got = {rdy[i], bsy[i], ox[i], oy[i], oz[i], cnt[i]};
        exp = {er, eb, ex, ey, ez, mcnt[i]};
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL cycle inst%0d m=%0d rdy/busy/x/y/z/cnt got %b/%b/%b/%b/%b/%h want %b/%b/%b/%b/%b/%h",
                   i, m, got[20], got[19], got[18], got[17], got[16], got[15:0],
                   exp[20], exp[19], exp[18], exp[17], exp[16], exp[15:0]);
        end
      end
    end
    m = m + 1;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        act[i] = 1'b0; mcnt[i] = '0; fr[i] = 0; bend[i] = 0;
      end else begin
        if (act[i] && (m == e[i] + wv[i])) begin
          mcnt[i] = mcnt[i] + 16'd1;
          act[i]  = 1'b0;
        end
        if (vin[i] && (m - 1 >= fr[i])) begin
          act[i]  = 1'b1;
          e[i]    = m;
          md[i]   = dat[i];
          fr[i]   = (gv[i] == 0) ? m + wv[i] - 1 : m + wv[i] + gv[i];
          bend[i] = m + wv[i] + gv[i];
        end
      end
    end
    if (!rst_n) started = 1'b1;
  end

  int zc = 0;
  bit zc_en = 1'b0;
  always @(negedge clk) if (zc_en && oz[2] === 1'b1) zc++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  initial begin
    logic [7:0] xs, ys, zs;
    logic       any_rdy;
    for (int i = 0; i < 3; i++) begin
      vin[i] = 1'b0;
      dat[i] = '0;
    end
    rst_n = 1'b0;
    repeat (2) tick;
    chk("reset_ready", {31'd0, rdy[0]}, 32'd0);
    chk("reset_busy",  {31'd0, bsy[0]}, 32'd0);
    chk("reset_cnt",   {16'd0, cnt[0]}, 32'd0);
    chk("reset_x",     {31'd0, ox[0]},  32'd0);
    rst_n = 1'b1;
    tick;
    chk("release_ready", {31'd0, rdy[0]}, 32'd1);

    // Basic frame A5 on 8/2
    vin[0] = 1'b1; dat[0] = 64'hA5;
    tick;
    vin[0] = 1'b0;
    xs = '0; ys = '0; zs = '0;
    for (int k = 0; k < 8; k++) begin
      xs = {xs[6:0], ox[0]}; ys = {ys[6:0], oy[0]}; zs = {zs[6:0], oz[0]};
      tick;
    end
    chk("t1_x", {24'd0, xs}, 32'hFF);
    chk("t1_y", {24'd0, ys}, 32'hA5);
    chk("t1_z", {24'd0, zs}, 32'h01);
    chk("t1_gap1_x", {31'd0, ox[0]}, 32'd0);
    tick;
    chk("t1_gap2_x",   {31'd0, ox[0]},  32'd0);
    chk("t1_gap2_rdy", {31'd0, rdy[0]}, 32'd0);
    tick;
    chk("t1_idle_rdy", {31'd0, rdy[0]}, 32'd1);
    chk("t1_cnt",      {16'd0, cnt[0]}, 32'd1);

    // Back-to-back F then 1 on 4/0
    vin[1] = 1'b1; dat[1] = 64'hF;
    tick;
    dat[1] = 64'h1;
    xs = '0; ys = '0; zs = '0;
    for (int k = 0; k < 8; k++) begin
      xs = {xs[6:0], ox[1]}; ys = {ys[6:0], oy[1]}; zs = {zs[6:0], oz[1]};
      if (k == 4) vin[1] = 1'b0;
      tick;
    end
    chk("t2_x",   {24'd0, xs}, 32'hFF);
    chk("t2_y",   {24'd0, ys}, 32'hF1);
    chk("t2_z",   {24'd0, zs}, 32'h11);
    chk("t2_cnt", {16'd0, cnt[1]}, 32'd2);
    chk("t2_rdy", {31'd0, rdy[1]}, 32'd1);

    // Hold-off: 3C offered throughout an FF frame on 8/2
    vin[0] = 1'b1; dat[0] = 64'hFF;
    tick;
    dat[0] = 64'h3C;
    any_rdy = 1'b0;
    for (int k = 0; k < 10; k++) begin
      any_rdy = any_rdy | rdy[0];
      tick;
    end
    chk("t3_holdoff", {31'd0, any_rdy}, 32'd0);
    chk("t3_idle_rdy", {31'd0, rdy[0]}, 32'd1);
    tick;
    vin[0] = 1'b0;
    ys = '0;
    for (int k = 0; k < 8; k++) begin
      ys = {ys[6:0], oy[0]};
      tick;
    end
    chk("t3_y", {24'd0, ys}, 32'h3C);
    repeat (3) tick;
    chk("t3_busy", {31'd0, bsy[0]}, 32'd0);
    chk("t3_cnt",  {16'd0, cnt[0]}, 32'd3);

    // Minimum width on 1/0
    vin[2] = 1'b1; dat[2] = 64'h1;
    tick;
    dat[2] = 64'h0;
    xs = {7'd0, ox[2]}; ys = {7'd0, oy[2]}; zs = {7'd0, oz[2]};
    tick;
    vin[2] = 1'b0;
    xs = {xs[6:0], ox[2]}; ys = {ys[6:0], oy[2]}; zs = {zs[6:0], oz[2]};
    tick;
    chk("t4_x",   {24'd0, xs}, 32'h03);
    chk("t4_y",   {24'd0, ys}, 32'h02);
    chk("t4_z",   {24'd0, zs}, 32'h03);
    chk("t4_cnt", {16'd0, cnt[2]}, 32'd2);

    // Reset at bit 3 of A5 on 8/2
    vin[0] = 1'b1; dat[0] = 64'hA5;
    tick;
    vin[0] = 1'b0;
    repeat (3) tick;
    rst_n = 1'b0;
    #1;
    chk("t5_rdy_in_reset", {31'd0, rdy[0]}, 32'd0);
    tick;
    chk("t5_xyz",  {29'd0, ox[0], oy[0], oz[0]}, 32'd0);
    chk("t5_busy", {31'd0, bsy[0]}, 32'd0);
    chk("t5_cnt",  {16'd0, cnt[0]}, 32'd0);
    tick;
    rst_n = 1'b1;
    #1;
    chk("t5_rdy_release", {31'd0, rdy[0]}, 32'd1);
    tick;

    // Counter wrap: 65536 one-bit frames on 1/0
    zc = 0; zc_en = 1'b1;
    vin[2] = 1'b1; dat[2] = 64'h1;
    tick;
    repeat (65535) tick;
    chk("t6_cnt_ffff", {16'd0, cnt[2]}, 32'h0000FFFF);
    vin[2] = 1'b0;
    tick;
    chk("t6_cnt_wrap", {16'd0, cnt[2]}, 32'd0);
    chk("t6_zpulses",  zc, 32'd65536);
    zc_en = 1'b0;
    repeat (3) tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/svi_serial_tx.md
# svi_serial_tx

Serial frame transmitter that drives the three-signal SVI bundle `I` through its output modport `I.P2` from a parallel valid/ready input. It is the producing end of the bundle: `x` is the bit strobe, `y` is the serial data bit and `z` marks the last bit of a frame. Consumers read the same interface instance through `I.P1`. The block is the legal-direction counterpart to the modport-direction checks, and it adds real sequential behaviour: a shift register, counters and an inter-frame gap.

## Interface
- `WIDTH`, default 8: bits per frame; legal range 1..64.
- `GAP`, default 2: idle cycles forced between frames; legal range 0..255.

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `in_valid`  input  1  parallel word offered.
- `in_ready`  output  1  block can accept a word this cycle.
- `in_data`  input  WIDTH  word to transmit, MSB first.
- `p2`  interface `I.P2`  3 (`x`, `y`, `z`, all outputs)  serial bundle; `x` strobe, `y` data, `z` last bit.
- `busy`  output  1  high while a frame or its gap is in progress.
- `frame_cnt`  output  16  count of completed frames.

## Operation
- FSM states:
  - IDLE: `in_ready`=1, `x`=`y`=`z`=0.
  - SHIFT: `x`=1, driving bits.
  - GAP: `x`=`y`=`z`=0, counting idle cycles.
- Accept rule: a word is accepted at a rising edge when `in_valid` && `in_ready`.
- On accept:
  - Load the shift register with `in_data`.
  - Register `x`=1 and `y`=`in_data[WIDTH-1]`.
  - Set remaining-bit counter `rem`=WIDTH-1 and register `z`=(WIDTH==1).
  - Go to SHIFT.
- SHIFT, each edge with `rem`>0:
  - `y` takes the next lower bit.
  - `rem` decrements.
  - `z` is registered as 1 exactly when the new `rem`==0.
- SHIFT, edge with `rem`==0 (the last bit is on the bus):
  - `frame_cnt` increments.
  - If GAP>0: go to GAP with gap counter=GAP-1 and drive the outputs to 0.
  - Else, if a new word is accepted at this edge: reload as on accept (back-to-back, `x` stays high).
  - Otherwise: go to IDLE.
- GAP: the gap counter decrements each edge. At 0 the next edge goes to IDLE.
- `in_ready` is combinational:
  - 1 in IDLE.
  - 1 in SHIFT when `rem`==0 and GAP==0.
  - 0 otherwise.
  - Forced 0 while `rst_n`=0.
- `in_data` is ignored except at acceptance. Changing it mid-frame has no effect.
- `busy` = (state != IDLE).
- `frame_cnt` wraps 16'hFFFF -> 0 without saturation.
- `x`, `y` and `z` are driven only through `p2`. The block never reads them back.

## Timing
- Reset: at the first edge with `rst_n`=0:
  - State goes to IDLE.
  - `x`=`y`=`z`=0, `busy`=0, `frame_cnt`=0.
  - Shift register and counters are cleared.
  - `in_ready`=0 while reset is held and 1 in the first cycle after release.
- Reset mid-frame or mid-gap: the frame is abandoned and `frame_cnt` is not incremented. Outputs are 0 from the cycle after the reset edge.
- Latency: the first bit appears on `p2` in the cycle after the accept edge, with no combinational path from `in_data` to `p2`.
- `x` is high for exactly WIDTH consecutive cycles per frame. `z` is high for exactly 1 cycle, coincident with the last `x` cycle.
- Frame-to-frame spacing:
  - GAP>0: GAP cycles with `x`=0, then at least one IDLE cycle with `in_ready`=1 before the next first bit. Minimum period is WIDTH+GAP+1 cycles.
  - GAP==0: back-to-back frames with period WIDTH and `x` continuously high.
- `in_valid` arriving during SHIFT or GAP is held off by `in_ready`=0. The block never drops or duplicates a word.

## Test plan
- Basic frame: WIDTH=8, GAP=2, `in_data`=8'hA5 accepted at edge k.
  - Cycles k+1..k+8: `x`=1 and `y`=1,0,1,0,0,1,0,1.
  - `z`=1 only at k+8.
  - `x`=0 at k+9 and k+10.
  - `in_ready`=1 at k+11 and `frame_cnt`=1.
- Back-to-back: GAP=0, WIDTH=4, `in_valid` held high with 4'hF then 4'h1.
  - `x` high for 8 consecutive cycles.
  - `y`=1,1,1,1,0,0,0,1.
  - `z` high at cycles 4 and 8.
  - `frame_cnt`=2.
- Hold-off: assert `in_valid` with 8'h3C on every cycle of a frame carrying 8'hFF.
  - `in_ready`=0 throughout SHIFT and GAP.
  - 8'h3C is transmitted once, starting only after the IDLE cycle.
- Minimum width: WIDTH=1, GAP=0, words 1'b1 then 1'b0.
  - Each frame is one cycle with `x`=`z`=1.
  - `y`=1 then 0.
- Reset mid-frame: drop `rst_n` at bit 3 of 8'hA5.
  - Next cycle `x`=`y`=`z`=0, `busy`=0, `frame_cnt` unchanged at 0.
  - `in_ready`=1 one cycle after release.
- Counter wrap: force 65536 one-bit frames (WIDTH=1, GAP=0) -> `frame_cnt` reads 16'h0000, and no `z` pulse is missing.
